// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator and the display path.
// The generator drives the counters and syncs; the consumer supplies the pixel enable.
interface vga_timing_gen_if;
  logic        pix_ce;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        in_active;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  pix_ce,
    output pixel_x, pixel_y, in_active, hsync, vsync, blank_n, line_start, frame_start
  );

  modport slave (
    output pix_ce,
    input  pixel_x, pixel_y, in_active, hsync, vsync, blank_n, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running x/y counters, sync/blank decode delayed to
// line up with the registered RGB pipeline, plus line/frame start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int PIPE_DELAY  = 2
) (
  input  logic               clk,
  input  logic               reset,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic bn;
  } dly_t;

  localparam dly_t DLY_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, bn: 1'b0};

  logic [10:0] x_q, x_d, y_q, y_d;
  logic        act_q, act_d;
  logic        ls_q, ls_d, fs_q, fs_d;
  logic        x_wrap, y_wrap;
  dly_t        raw;

  always_comb begin
    x_wrap = (x_q == X_LAST);
    y_wrap = (y_q == Y_LAST);
    x_d    = x_q;
    y_d    = y_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    if (vga.pix_ce) begin
      x_d  = x_wrap ? 11'd0 : x_q + 11'd1;
      if (x_wrap) y_d = y_wrap ? 11'd0 : y_q + 11'd1;
      ls_d = x_wrap;
      fs_d = x_wrap && y_wrap;
    end
    // in_active is computed from the next counters so it tracks pixel_x/pixel_y exactly
    act_d  = (x_d < X_ACT) && (y_d < Y_ACT);
    raw.hs = ((x_q >= HS_BEG) && (x_q <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    raw.vs = ((y_q >= VS_BEG) && (y_q <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    raw.bn = act_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      act_q <= 1'b1;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign vga.hsync   = raw.hs;
      assign vga.vsync   = raw.vs;
      assign vga.blank_n = raw.bn;
    end else begin : g_dly
      dly_t dly_q [PIPE_DELAY];

      // Reset flushes every stage so no partial sync pulse survives.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= DLY_IDLE;
        end else if (vga.pix_ce) begin
          dly_q[0] <= raw;
          for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign vga.hsync   = dly_q[PIPE_DELAY-1].hs;
      assign vga.vsync   = dly_q[PIPE_DELAY-1].vs;
      assign vga.blank_n = dly_q[PIPE_DELAY-1].bn;
    end
  endgenerate

  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.in_active   = act_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken 13x7 raster so whole frames stay short.
module tb_vga_timing_gen;
  localparam int HA = 6, HF = 2, HS = 3, HB = 2;
  localparam int VA = 3, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 13
  localparam int VT = VA + VF + VS + VB;  // 7
  localparam int PD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   p = 0;
  logic ls_e = 1'b0, fs_e = 1'b0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .PIPE_DELAY(PD)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .vga   (vif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic ce;
    int   x;   int   y;
    logic ia;  logic hs; logic vs; logic bn; logic ls; logic fs;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // {hs, vs, blank_n} for raster position q counted in pixels since (0,0)
  function automatic logic [2:0] dec(input int q);
    int hx, vy;
    hx = q % HT;
    vy = (q / HT) % VT;
    dec[2] = (hx >= HA + HF && hx <= HA + HF + HS - 1) ? 1'b0 : 1'b1;
    dec[1] = (vy >= VA + VF && vy <= VA + VF + VS - 1) ? 1'b0 : 1'b1;
    dec[0] = (hx < HA) && (vy < VA);
  endfunction

  task automatic step(input logic r, input logic c);
    logic [2:0] d;
    int ex, ey;
    rst = r;
    vif.pix_ce = c;
    @(posedge clk);
    #1;
    if (r) begin
      p = 0; ls_e = 1'b0; fs_e = 1'b0;
    end else if (c) begin
      p++;
      ls_e = (p % HT) == 0;
      fs_e = (p % (HT * VT)) == 0;
    end else begin
      ls_e = 1'b0; fs_e = 1'b0;
    end
    ex = p % HT;
    ey = (p / HT) % VT;
    d  = (p >= PD) ? dec(p - PD) : 3'b110;
    chk("m.x",  vif.pixel_x, ex);
    chk("m.y",  vif.pixel_y, ey);
    chk("m.ia", vif.in_active, (ex < HA) && (ey < VA));
    chk("m.hs", vif.hsync, d[2]);
    chk("m.vs", vif.vsync, d[1]);
    chk("m.bn", vif.blank_n, d[0]);
    chk("m.ls", vif.line_start, ls_e);
    chk("m.fs", vif.frame_start, fs_e);
  endtask

  initial begin
    int nvs, nfs, nls, nhs, first_ls, second_ls;
    vif.pix_ce = 1'b0;

    //           rst ce  x  y ia hs vs bn ls fs
    vt[0]  = '{1, 0,  0, 0, 1, 1, 1, 0, 0, 0};
    vt[1]  = '{1, 1,  0, 0, 1, 1, 1, 0, 0, 0};
    vt[2]  = '{0, 1,  1, 0, 1, 1, 1, 0, 0, 0};
    vt[3]  = '{0, 1,  2, 0, 1, 1, 1, 1, 0, 0};
    vt[4]  = '{0, 0,  2, 0, 1, 1, 1, 1, 0, 0};
    vt[5]  = '{0, 1,  3, 0, 1, 1, 1, 1, 0, 0};
    vt[6]  = '{0, 1,  4, 0, 1, 1, 1, 1, 0, 0};
    vt[7]  = '{0, 1,  5, 0, 1, 1, 1, 1, 0, 0};
    vt[8]  = '{0, 1,  6, 0, 0, 1, 1, 1, 0, 0};
    vt[9]  = '{0, 1,  7, 0, 0, 1, 1, 1, 0, 0};
    vt[10] = '{0, 1,  8, 0, 0, 1, 1, 0, 0, 0};
    vt[11] = '{0, 1,  9, 0, 0, 1, 1, 0, 0, 0};
    vt[12] = '{0, 1, 10, 0, 0, 0, 1, 0, 0, 0};
    vt[13] = '{0, 1, 11, 0, 0, 0, 1, 0, 0, 0};
    vt[14] = '{0, 1, 12, 0, 0, 0, 1, 0, 0, 0};
    vt[15] = '{0, 1,  0, 1, 1, 1, 1, 0, 1, 0};
    vt[16] = '{0, 0,  0, 1, 1, 1, 1, 0, 0, 0};
    vt[17] = '{0, 1,  1, 1, 1, 1, 1, 0, 0, 0};
    vt[18] = '{0, 1,  2, 1, 1, 1, 1, 1, 0, 0};
    vt[19] = '{1, 1,  0, 0, 1, 1, 1, 0, 0, 0};
    vt[20] = '{0, 1,  1, 0, 1, 1, 1, 0, 0, 0};
    vt[21] = '{0, 1,  2, 0, 1, 1, 1, 1, 0, 0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) begin
      rst = vt[i].rst;
      vif.pix_ce = vt[i].ce;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.x", i),  vif.pixel_x,     vt[i].x);
      chk($sformatf("vec%0d.y", i),  vif.pixel_y,     vt[i].y);
      chk($sformatf("vec%0d.ia", i), vif.in_active,   vt[i].ia);
      chk($sformatf("vec%0d.hs", i), vif.hsync,       vt[i].hs);
      chk($sformatf("vec%0d.vs", i), vif.vsync,       vt[i].vs);
      chk($sformatf("vec%0d.bn", i), vif.blank_n,     vt[i].bn);
      chk($sformatf("vec%0d.ls", i), vif.line_start,  vt[i].ls);
      chk($sformatf("vec%0d.fs", i), vif.frame_start, vt[i].fs);
    end

    // Two full frames with pix_ce held high
    step(1'b1, 1'b0);
    nvs = 0; nfs = 0; nls = 0;
    for (int k = 0; k < 2 * HT * VT; k++) begin
      step(1'b0, 1'b1);
      if (vif.vsync == 1'b0) nvs++;
      if (vif.frame_start)   nfs++;
      if (vif.line_start)    nls++;
    end
    chk("frames.vsync_width", nvs, 2 * VS * HT);
    chk("frames.frame_start", nfs, 2);
    chk("frames.line_start",  nls, 2 * VT);

    // pix_ce alternating: half-rate raster
    step(1'b1, 1'b0);
    nhs = 0; first_ls = -1; second_ls = -1;
    for (int k = 1; k <= 4 * HT; k++) begin
      step(1'b0, k[0]);
      if (vif.hsync == 1'b0) nhs++;
      if (vif.line_start) begin
        if (first_ls < 0) first_ls = k;
        else if (second_ls < 0) second_ls = k;
      end
    end
    chk("half.hsync_clks", nhs, 2 * 2 * HS);
    chk("half.first_ls",   first_ls, 2 * HT - 1);
    chk("half.line_clks",  second_ls - first_ls, 2 * HT);

    // Reset landing inside both sync pulses, with pix_ce low on the reset edge
    step(1'b1, 1'b0);
    for (int k = 0; k < (VA + VF) * HT + 11; k++) step(1'b0, 1'b1);
    chk("mid.hs_before", vif.hsync, 1'b0);
    chk("mid.vs_before", vif.vsync, 1'b0);
    step(1'b1, 1'b0);
    chk("mid.x", vif.pixel_x, 0);
    chk("mid.y", vif.pixel_y, 0);
    chk("mid.hs", vif.hsync, 1'b1);
    chk("mid.vs", vif.vsync, 1'b1);
    chk("mid.bn", vif.blank_n, 1'b0);
    step(1'b0, 1'b1);
    chk("mid.bn_1ce", vif.blank_n, 1'b0);
    step(1'b0, 1'b1);
    chk("mid.bn_2ce", vif.blank_n, 1'b1);

    // Reset and pix_ce both held for 5 clks, then resume from 0
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
    chk("hold.x", vif.pixel_x, 0);
    step(1'b0, 1'b1);
    chk("resume.x", vif.pixel_x, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
